// File: rtl/ins_dec_pipe.sv
// Registered instruction decoder with a 2-entry output/skid buffer,
// RUN/HALTED flow control, flush and a saturating illegal-opcode counter.
module ins_dec_pipe #(
  parameter int INSTR_W    = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_REGS   = 32,
  parameter int OPCODE_W   = 6,
  parameter int CNT_W      = 8,
  parameter int IMM_SIGNED = 1,
  localparam int RA_W      = $clog2(NUM_REGS),
  localparam int IMM_W     = INSTR_W - OPCODE_W - 2*RA_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [INSTR_W-1:0] in_instr_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic               flush_i,
  input  logic               resume_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [RA_W-1:0]    rd_o,
  output logic [RA_W-1:0]    rs1_o,
  output logic [RA_W-1:0]    rs2_o,
  output logic [DATA_W-1:0]  imm_o,
  output logic [2:0]         alu_op_o,
  output logic               use_imm_o,
  output logic               reg_we_o,
  output logic               mem_re_o,
  output logic               mem_we_o,
  output logic               branch_o,
  output logic               jump_o,
  output logic               halt_o,
  output logic               illegal_o,
  output logic [CNT_W-1:0]   illegal_cnt_o,
  output logic               halted_o
);

  localparam int DEC_W = 3*RA_W + DATA_W + 3 + 8;

  typedef enum logic {RUN, HALTED} state_t;

  logic [OPCODE_W-1:0] w_opcode;
  logic [RA_W-1:0]     w_rd;
  logic [RA_W-1:0]     w_rs1;
  logic [RA_W-1:0]     w_rs2;
  logic [IMM_W-1:0]    w_imm;
  logic [DATA_W-1:0]   w_immExt;
  logic [2:0]          w_aluOp;
  logic                w_useImm;
  logic                w_regWe;
  logic                w_memRe;
  logic                w_memWe;
  logic                w_branch;
  logic                w_jump;
  logic                w_halt;
  logic                w_illegal;
  logic [DEC_W-1:0]    w_dec;
  logic                w_accept;
  logic                w_outFree;
  logic                w_skidValidNxt;

  logic [DEC_W-1:0]    r_out;
  logic                r_outValid;
  logic [DEC_W-1:0]    r_skid;
  logic                r_skidValid;
  logic                r_inReady;
  logic [CNT_W-1:0]    r_illCnt;
  state_t              r_state;

  assign w_opcode = in_instr_i[INSTR_W-1 -: OPCODE_W];
  assign w_rd     = in_instr_i[INSTR_W-OPCODE_W-1 -: RA_W];
  assign w_rs1    = in_instr_i[INSTR_W-OPCODE_W-RA_W-1 -: RA_W];
  assign w_imm    = in_instr_i[IMM_W-1:0];
  assign w_rs2    = w_imm[RA_W-1:0];

  generate
    if (DATA_W > IMM_W) begin : g_extend
      if (IMM_SIGNED != 0) begin : g_sext
        assign w_immExt = {{(DATA_W-IMM_W){w_imm[IMM_W-1]}}, w_imm};
      end else begin : g_zext
        assign w_immExt = {{(DATA_W-IMM_W){1'b0}}, w_imm};
      end
    end else begin : g_trunc
      assign w_immExt = w_imm[DATA_W-1:0];
    end
  endgenerate

  always_comb begin
    w_aluOp   = 3'd0;
    w_useImm  = 1'b0;
    w_regWe   = 1'b0;
    w_memRe   = 1'b0;
    w_memWe   = 1'b0;
    w_branch  = 1'b0;
    w_jump    = 1'b0;
    w_halt    = 1'b0;
    w_illegal = 1'b0;
    case (w_opcode)
      OPCODE_W'(0):  ;
      OPCODE_W'(1):  w_regWe = 1'b1;
      OPCODE_W'(2):  begin w_regWe = 1'b1; w_aluOp = 3'd1; end
      OPCODE_W'(3):  begin w_regWe = 1'b1; w_aluOp = 3'd2; end
      OPCODE_W'(4):  begin w_regWe = 1'b1; w_aluOp = 3'd3; end
      OPCODE_W'(5):  begin w_regWe = 1'b1; w_aluOp = 3'd4; end
      OPCODE_W'(6):  begin w_regWe = 1'b1; w_useImm = 1'b1; end
      OPCODE_W'(7):  begin w_regWe = 1'b1; w_useImm = 1'b1; w_memRe = 1'b1; end
      OPCODE_W'(8):  begin w_useImm = 1'b1; w_memWe = 1'b1; end
      OPCODE_W'(9):  begin w_branch = 1'b1; w_useImm = 1'b1; w_aluOp = 3'd1; end
      OPCODE_W'(10): begin w_jump = 1'b1; w_useImm = 1'b1; end
      OPCODE_W'(11): w_halt = 1'b1;
      default:       w_illegal = 1'b1;
    endcase
  end

  assign w_dec = {w_rd, w_rs1, w_rs2, w_immExt, w_aluOp, w_useImm, w_regWe,
                  w_memRe, w_memWe, w_branch, w_jump, w_halt, w_illegal};

  assign w_accept  = in_valid_i && r_inReady;
  assign w_outFree = !r_outValid || out_ready_i;
  // The skid entry only fills when an accept lands on a stalled output.
  assign w_skidValidNxt = w_outFree ? 1'b0 : (r_skidValid || w_accept);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out       <= '0;
      r_outValid  <= 1'b0;
      r_skid      <= '0;
      r_skidValid <= 1'b0;
      r_inReady   <= 1'b1;
      r_illCnt    <= '0;
      r_state     <= RUN;
    end else if (flush_i) begin
      r_outValid  <= 1'b0;
      r_skidValid <= 1'b0;
      r_inReady   <= 1'b1;
      r_state     <= RUN;
    end else begin
      if (w_outFree) begin
        if (r_skidValid) begin
          r_out      <= r_skid;
          r_outValid <= 1'b1;
        end else if (w_accept) begin
          r_out      <= w_dec;
          r_outValid <= 1'b1;
        end else begin
          r_outValid <= 1'b0;
        end
      end else if (w_accept) begin
        r_skid <= w_dec;
      end
      r_skidValid <= w_skidValidNxt;

      if (w_accept && w_illegal && (r_illCnt != {CNT_W{1'b1}}))
        r_illCnt <= r_illCnt + 1'b1;

      case (r_state)
        RUN: begin
          if (w_accept && w_halt) begin
            r_state   <= HALTED;
            r_inReady <= 1'b0;
          end else begin
            r_inReady <= !w_skidValidNxt;
          end
        end
        HALTED: begin
          if (resume_i) begin
            r_state   <= RUN;
            r_inReady <= !w_skidValidNxt;
          end else begin
            r_inReady <= 1'b0;
          end
        end
        default: begin
          r_state   <= RUN;
          r_inReady <= !w_skidValidNxt;
        end
      endcase
    end
  end

  assign {rd_o, rs1_o, rs2_o, imm_o, alu_op_o, use_imm_o, reg_we_o,
          mem_re_o, mem_we_o, branch_o, jump_o, halt_o, illegal_o} = r_out;

  assign out_valid_o   = r_outValid;
  assign in_ready_o    = r_inReady;
  assign illegal_cnt_o = r_illCnt;
  assign halted_o      = (r_state == HALTED);

endmodule

// File: tb/tb_ins_dec_pipe.sv
// Directed bench for ins_dec_pipe: instance A uses defaults, instance B
// zero-extends the immediate and has a 2-bit illegal counter.
module tb_ins_dec_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        inValid;
  logic        flush;
  logic        resume;
  logic        outReady;

  logic        aReady, aValid, aUseImm, aRegWe, aMemRe, aMemWe, aBranch, aJump, aHalt, aIllegal, aHalted;
  logic [4:0]  aRd, aRs1, aRs2;
  logic [31:0] aImm;
  logic [2:0]  aAluOp;
  logic [7:0]  aCnt;

  logic        bReady, bValid, bUseImm, bRegWe, bMemRe, bMemWe, bBranch, bJump, bHalt, bIllegal, bHalted;
  logic [4:0]  bRd, bRs1, bRs2;
  logic [31:0] bImm;
  logic [2:0]  bAluOp;
  logic [1:0]  bCnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ins_dec_pipe dutA (
    .clk_i(clk), .rst_i(rst), .in_instr_i(instr), .in_valid_i(inValid), .in_ready_o(aReady),
    .flush_i(flush), .resume_i(resume), .out_valid_o(aValid), .out_ready_i(outReady),
    .rd_o(aRd), .rs1_o(aRs1), .rs2_o(aRs2), .imm_o(aImm), .alu_op_o(aAluOp),
    .use_imm_o(aUseImm), .reg_we_o(aRegWe), .mem_re_o(aMemRe), .mem_we_o(aMemWe),
    .branch_o(aBranch), .jump_o(aJump), .halt_o(aHalt), .illegal_o(aIllegal),
    .illegal_cnt_o(aCnt), .halted_o(aHalted)
  );

  ins_dec_pipe #(.CNT_W(2), .IMM_SIGNED(0)) dutB (
    .clk_i(clk), .rst_i(rst), .in_instr_i(instr), .in_valid_i(inValid), .in_ready_o(bReady),
    .flush_i(flush), .resume_i(resume), .out_valid_o(bValid), .out_ready_i(outReady),
    .rd_o(bRd), .rs1_o(bRs1), .rs2_o(bRs2), .imm_o(bImm), .alu_op_o(bAluOp),
    .use_imm_o(bUseImm), .reg_we_o(bRegWe), .mem_re_o(bMemRe), .mem_we_o(bMemWe),
    .branch_o(bBranch), .jump_o(bJump), .halt_o(bHalt), .illegal_o(bIllegal),
    .illegal_cnt_o(bCnt), .halted_o(bHalted)
  );

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr = 32'h0; inValid = 1'b0; flush = 1'b0; resume = 1'b0; outReady = 1'b0;
    step();
    rst = 1'b0;
    total++; if (aValid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid: got %0h want 0", aValid); end
    total++; if (aReady !== 1'b1) begin bad++; $display("[TB] FAIL rst_ready: got %0h want 1", aReady); end
    total++; if (aHalted !== 1'b0) begin bad++; $display("[TB] FAIL rst_halted: got %0h want 0", aHalted); end
    total++; if (aCnt !== 8'd0) begin bad++; $display("[TB] FAIL rst_cnt: got %0d want 0", aCnt); end
    total++; if ({aRd, aRs1, aRs2, aImm, aAluOp, aRegWe, aIllegal} !== '0) begin
      bad++; $display("[TB] FAIL rst_fields: got rd=%0d imm=%0h alu=%0d", aRd, aImm, aAluOp); end
  endtask

  task automatic test_add();
    outReady = 1'b1; inValid = 1'b1; instr = enc(6'd1, 5'd3, 5'd1, 16'h0002);
    step();
    inValid = 1'b0;
    total++; if (aValid !== 1'b1) begin bad++; $display("[TB] FAIL add_valid: got %0h want 1", aValid); end
    total++; if (aAluOp !== 3'd0) begin bad++; $display("[TB] FAIL add_alu: got %0d want 0", aAluOp); end
    total++; if (aRegWe !== 1'b1) begin bad++; $display("[TB] FAIL add_we: got %0h want 1", aRegWe); end
    total++; if ({aRd, aRs1, aRs2} !== {5'd3, 5'd1, 5'd2}) begin
      bad++; $display("[TB] FAIL add_regs: got %0d/%0d/%0d want 3/1/2", aRd, aRs1, aRs2); end
    total++; if ({aUseImm, aMemRe, aMemWe, aBranch, aJump, aHalt, aIllegal} !== 7'd0) begin
      bad++; $display("[TB] FAIL add_flags: got %b want 0", {aUseImm, aMemRe, aMemWe, aBranch, aJump, aHalt, aIllegal}); end
    step();
    total++; if (aValid !== 1'b0) begin bad++; $display("[TB] FAIL add_drain: got %0h want 0", aValid); end
  endtask

  task automatic test_imm();
    outReady = 1'b1; inValid = 1'b1; instr = 32'h1820FFFF;
    step();
    inValid = 1'b0;
    total++; if (aImm !== 32'hFFFFFFFF) begin bad++; $display("[TB] FAIL imm_sext: got %0h want ffffffff", aImm); end
    total++; if (bImm !== 32'h0000FFFF) begin bad++; $display("[TB] FAIL imm_zext: got %0h want 0000ffff", bImm); end
    total++; if ({aUseImm, aRegWe, aRd, aRs1} !== {1'b1, 1'b1, 5'd1, 5'd0}) begin
      bad++; $display("[TB] FAIL imm_ctrl: got use=%0h we=%0h rd=%0d rs1=%0d", aUseImm, aRegWe, aRd, aRs1); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [6] = '{6'd2, 6'd3, 6'd4, 6'd5, 6'd10, 6'd0};
    logic [2:0] alus [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0};
    logic [1:0] flg  [6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00};
    outReady = 1'b1; inValid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      instr = enc(ops[i], 5'(i + 1), 5'd2, 16'h0007);
      step();
      total++; if ({aValid, aReady, aRd, aAluOp, aRegWe, aJump} !== {1'b1, 1'b1, 5'(i + 1), alus[i], flg[i]}) begin
        bad++; $display("[TB] FAIL b2b_%0d: got v=%0h r=%0h rd=%0d alu=%0d we=%0h j=%0h want rd=%0d alu=%0d we/j=%b",
                        i, aValid, aReady, aRd, aAluOp, aRegWe, aJump, i + 1, alus[i], flg[i]); end
    end
    inValid = 1'b0;
    step();
    total++; if (aValid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_drain: got %0h want 0", aValid); end
  endtask

  task automatic test_skid();
    outReady = 1'b0; inValid = 1'b1; instr = enc(6'd7, 5'd4, 5'd5, 16'h0010);
    step();
    total++; if ({aValid, aReady, aRd, aMemRe} !== {1'b1, 1'b1, 5'd4, 1'b1}) begin
      bad++; $display("[TB] FAIL skid_ld: got v=%0h r=%0h rd=%0d re=%0h", aValid, aReady, aRd, aMemRe); end
    instr = enc(6'd8, 5'd6, 5'd7, 16'h0020);
    step();
    total++; if (aReady !== 1'b0) begin bad++; $display("[TB] FAIL skid_full: got %0h want 0", aReady); end
    total++; if ({aValid, aRd, aMemRe, aImm} !== {1'b1, 5'd4, 1'b1, 32'h10}) begin
      bad++; $display("[TB] FAIL skid_hold: got v=%0h rd=%0d re=%0h imm=%0h", aValid, aRd, aMemRe, aImm); end
    instr = enc(6'd9, 5'd8, 5'd9, 16'h0003); outReady = 1'b1;
    step();
    total++; if ({aValid, aReady, aRd, aMemWe, aMemRe} !== {1'b1, 1'b1, 5'd6, 1'b1, 1'b0}) begin
      bad++; $display("[TB] FAIL skid_st: got v=%0h r=%0h rd=%0d we=%0h re=%0h", aValid, aReady, aRd, aMemWe, aMemRe); end
    step();
    inValid = 1'b0;
    total++; if ({aValid, aRd, aBranch, aAluOp, aUseImm} !== {1'b1, 5'd8, 1'b1, 3'd1, 1'b1}) begin
      bad++; $display("[TB] FAIL skid_beq: got v=%0h rd=%0d br=%0h alu=%0d ui=%0h", aValid, aRd, aBranch, aAluOp, aUseImm); end
    step();
    total++; if (aValid !== 1'b0) begin bad++; $display("[TB] FAIL skid_nodup: got %0h want 0", aValid); end
  endtask

  task automatic test_halt();
    outReady = 1'b1; inValid = 1'b1; instr = enc(6'd11, 5'd0, 5'd0, 16'h0000);
    step();
    total++; if ({aValid, aHalt, aHalted, aReady, aRegWe} !== 5'b11100) begin
      bad++; $display("[TB] FAIL halt_deliver: got v=%0h h=%0h hd=%0h r=%0h we=%0h", aValid, aHalt, aHalted, aReady, aRegWe); end
    instr = enc(6'd1, 5'd7, 5'd1, 16'h0002);
    step();
    total++; if ({aValid, aReady, aHalted} !== 3'b001) begin
      bad++; $display("[TB] FAIL halt_block: got v=%0h r=%0h hd=%0h want 0/0/1", aValid, aReady, aHalted); end
    resume = 1'b1;
    step();
    resume = 1'b0;
    total++; if ({aValid, aReady, aHalted} !== 3'b010) begin
      bad++; $display("[TB] FAIL halt_resume: got v=%0h r=%0h hd=%0h want 0/1/0", aValid, aReady, aHalted); end
    step();
    inValid = 1'b0;
    total++; if ({aValid, aRd, aRegWe} !== {1'b1, 5'd7, 1'b1}) begin
      bad++; $display("[TB] FAIL halt_add: got v=%0h rd=%0d we=%0h want 1/7/1", aValid, aRd, aRegWe); end
    step();
  endtask

  task automatic test_illegal();
    int expB;
    rst = 1'b1;
    step();
    rst = 1'b0; outReady = 1'b1; inValid = 1'b1; instr = 32'hFC001234;
    for (int k = 1; k <= 5; k++) begin
      step();
      expB = (k < 3) ? k : 3;
      total++; if ({aValid, aIllegal, bIllegal, aRegWe, aUseImm, aAluOp} !== {3'b111, 2'b00, 3'd0}) begin
        bad++; $display("[TB] FAIL ill_flags_%0d: got v=%0h il=%0h/%0h we=%0h ui=%0h alu=%0d", k, aValid, aIllegal, bIllegal, aRegWe, aUseImm, aAluOp); end
      total++; if ({aCnt, bCnt} !== {8'(k), 2'(expB)}) begin
        bad++; $display("[TB] FAIL ill_cnt_%0d: got %0d/%0d want %0d/%0d", k, aCnt, bCnt, k, expB); end
    end
    inValid = 1'b0;
    step(); step();
    total++; if (bCnt !== 2'd3) begin bad++; $display("[TB] FAIL ill_sat: got %0d want 3", bCnt); end
  endtask

  task automatic test_flush();
    outReady = 1'b0; inValid = 1'b1; instr = enc(6'd1, 5'd1, 5'd0, 16'h0000);
    step();
    instr = enc(6'd1, 5'd2, 5'd0, 16'h0000);
    step();
    total++; if ({aValid, aReady} !== 2'b10) begin bad++; $display("[TB] FAIL flush_full: got v=%0h r=%0h", aValid, aReady); end
    flush = 1'b1; instr = 32'hFC000000;
    step();
    total++; if ({aValid, aReady} !== 2'b01) begin bad++; $display("[TB] FAIL flush_clear: got v=%0h r=%0h want 0/1", aValid, aReady); end
    step();
    total++; if ({aValid, aCnt, bCnt} !== {1'b0, 8'd5, 2'd3}) begin
      bad++; $display("[TB] FAIL flush_drop: got v=%0h cnt=%0d/%0d want 0/5/3", aValid, aCnt, bCnt); end
    flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
    step();
    total++; if (aValid !== 1'b0) begin bad++; $display("[TB] FAIL flush_nothing: got %0h want 0", aValid); end
  endtask

  task automatic test_reset_mid();
    outReady = 1'b0; inValid = 1'b1; instr = enc(6'd1, 5'd3, 5'd1, 16'h0002);
    step();
    instr = enc(6'd2, 5'd4, 5'd1, 16'h8002);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if ({aValid, aReady, aHalted, aCnt, bCnt} !== {3'b010, 8'd0, 2'd0}) begin
      bad++; $display("[TB] FAIL rstmid_ctrl: got v=%0h r=%0h hd=%0h cnt=%0d/%0d", aValid, aReady, aHalted, aCnt, bCnt); end
    total++; if ({aRd, aRs1, aRs2, aImm, aAluOp, aUseImm, aRegWe, aMemRe, aMemWe, aBranch, aJump, aHalt, aIllegal} !== '0) begin
      bad++; $display("[TB] FAIL rstmid_fields: got rd=%0d imm=%0h alu=%0d we=%0h", aRd, aImm, aAluOp, aRegWe); end
    inValid = 1'b0; outReady = 1'b1;
    step();
    total++; if (aValid !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_lost: got %0h want 0", aValid); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_imm();
    test_back_to_back();
    test_skid();
    test_halt();
    test_illegal();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
